// File: rtl/clint_pkg.sv
// Shared types and constants for the CLINT MMIO master: access sizes, FSM states,
// default CLINT window and register offsets.
package clint_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_ISSUE,
        RESP
    } state_t;

    localparam logic [63:0] CLINT_BASE_DEFAULT = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINT_SIZE_DEFAULT = 64'h0000_0000_0001_0000;

    localparam logic [15:0] MTIME_OFF    = 16'hbff8;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;

endpackage

// File: rtl/clint_lane_align.sv
// Byte-lane helper: extracts and sign-extends a sub-word load from a CLINT dword,
// and merges sub-word store data into a previously read dword.
module clint_lane_align
    import clint_pkg::*;
(
    input  logic [63:0] rd_dword,
    input  logic [63:0] wr_data,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] lane_mask;
    logic        sign_bit;

    always_comb begin
        shamt     = {offset, 3'b000};
        lane      = rd_dword >> shamt;
        lane_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            SZ_B: begin
                lane_mask = 64'h0000_0000_0000_00ff;
                sign_bit  = lane[7];
            end
            SZ_H: begin
                lane_mask = 64'h0000_0000_0000_ffff;
                sign_bit  = lane[15];
            end
            SZ_W: begin
                lane_mask = 64'h0000_0000_ffff_ffff;
                sign_bit  = lane[31];
            end
            default: begin
                lane_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        // For a dword the mask is all ones, so the fill term vanishes on its own.
        load_data = (lane & lane_mask) | ((sign_bit && !is_unsigned) ? ~lane_mask : '0);
        merged    = (rd_dword & ~(lane_mask << shamt)) | ((wr_data & lane_mask) << shamt);
    end

endmodule

// File: rtl/clint_mmio_master.sv
// LSU-side bus initiator for the CLINT register port: turns sized load/store requests
// into full-dword CLINT cycles, with read-modify-write for partial stores.
module clint_mmio_master
    import clint_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEFAULT,
    parameter logic [63:0] CLINT_SIZE = CLINT_SIZE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [63:0]           req_addr,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [63:0]           clint_addr,
    output logic [DATA_WIDTH-1:0] clint_wdata,
    output logic                  clint_wen,
    output logic                  clint_sel,
    input  logic [DATA_WIDTH-1:0] clint_rdata
);

    state_t                state;
    state_t                state_next;
    logic [2:0]            cap_offset;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic                  cap_wen;
    logic [63:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [2:0]            align_mask;
    logic [63:0]           window_off;
    logic                  misaligned;
    logic                  out_of_window;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        align_mask = 3'b111;
        case (req_size)
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        // The subtraction wraps for addresses below the base, hence the separate compare.
        window_off    = req_addr - CLINT_BASE;
        misaligned    = |(req_addr[2:0] & align_mask);
        out_of_window = (req_addr < CLINT_BASE) || (window_off >= CLINT_SIZE);
        req_err       = misaligned || out_of_window;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        clint_sel  = 1'b0;
        clint_wen  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_wen && req_size == SZ_D) begin
                        state_next = WR_ISSUE;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                clint_sel  = 1'b1;
                state_next = RD_DATA;
            end
            RD_DATA: begin
                state_next = cap_wen ? WR_ISSUE : RESP;
            end
            WR_ISSUE: begin
                clint_sel  = 1'b1;
                clint_wen  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // wdata_q holds the raw store data from accept, and is overwritten by the merged
    // dword in RD_DATA when the store is partial.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_offset   <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_wen      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else if (req_ready && req_valid) begin
            cap_offset   <= req_addr[2:0];
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_wen      <= req_wen;
            addr_q       <= {req_addr[63:3], 3'b000};
            wdata_q      <= req_wdata;
            rdata_q      <= '0;
            err_q        <= req_err;
        end else if (state == RD_DATA) begin
            if (cap_wen) begin
                wdata_q <= merged;
            end else begin
                rdata_q <= load_data;
            end
        end
    end

    clint_lane_align u_lane_align (
        .rd_dword    (clint_rdata),
        .wr_data     (wdata_q),
        .offset      (cap_offset),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign clint_addr  = addr_q;
    assign clint_wdata = (state == WR_ISSUE) ? wdata_q : '0;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_clint_mmio_master.sv
// Scoreboard bench for clint_mmio_master against a small behavioural CLINT with
// registered, enable-gated reads.
module tb_clint_mmio_master;
    import clint_pkg::*;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          n_sel;
        int          n_wr;
        logic [63:0] wdata;
        logic [63:0] caddr;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] clint_addr;
    logic [63:0] clint_wdata;
    logic        clint_wen;
    logic        clint_sel;
    logic [63:0] clint_rdata;

    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          acc_cycle = 0;
    int          lat = 0;
    int          seen_sel = 0;
    int          seen_wr = 0;
    logic [63:0] seen_wdata;
    logic [63:0] seen_addr;
    logic [63:0] held_rdata;
    logic        held_err;
    logic        rsp_seen = 1'b0;
    logic        idle_chk = 1'b0;
    logic        done = 1'b0;

    clint_mmio_master dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .clint_addr   (clint_addr),
        .clint_wdata  (clint_wdata),
        .clint_wen    (clint_wen),
        .clint_sel    (clint_sel),
        .clint_rdata  (clint_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // CLINT model: not reset by the master's reset, so an aborted write shows up as a lost update.
    initial begin
        mtime_q     = 64'h0;
        mtimecmp_q  = 64'h0;
        clint_rdata = 64'h0;
    end

    always @(posedge clock) begin
        if (clint_sel) begin
            if (clint_wen) begin
                if (clint_addr[15:0] == MTIMECMP_OFF) mtimecmp_q <= clint_wdata;
                else if (clint_addr[15:0] == MTIME_OFF) mtime_q <= clint_wdata;
            end else begin
                if (clint_addr[15:0] == MTIMECMP_OFF) clint_rdata <= mtimecmp_q;
                else if (clint_addr[15:0] == MTIME_OFF) clint_rdata <= mtime_q;
                else clint_rdata <= 64'h0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat,
                                  input int exp_nsel, input int exp_nwr, input logic [63:0] exp_wdata);
        exp_t e;
        int   waited;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.n_sel = exp_nsel;
        e.n_wr  = exp_nwr;
        e.wdata = exp_wdata;
        e.caddr = {addr[63:3], 3'b000};
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wen      = wen;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL req_timeout: got req_ready=0 after %0d cycles, expected 1", waited);
            void'(exp_q.pop_back());
            req_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clock);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rsp_timeout: got %0d responses pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor_step();
        if (reset) begin
            rsp_seen = 1'b0;
            idle_chk = 1'b0;
            return;
        end
        if (idle_chk) begin
            check_output("idle_after_rsp", 64'(req_ready), 64'h1);
            idle_chk = 1'b0;
        end
        if (clint_sel) begin
            seen_sel++;
            seen_addr = clint_addr;
            if (clint_wen) begin
                seen_wr++;
                seen_wdata = clint_wdata;
            end
        end
        if (rsp_valid) begin
            if (!rsp_seen) begin
                rsp_seen   = 1'b1;
                lat        = cycle - acc_cycle;
                held_rdata = rsp_rdata;
                held_err   = rsp_err;
            end else begin
                check_output("rsp_rdata_stable", rsp_rdata, held_rdata);
                check_output("rsp_err_stable", 64'(rsp_err), 64'(held_err));
            end
            check_output("req_ready_in_resp", 64'(req_ready), 64'h0);
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got a response, expected none");
                end else begin
                    cur = exp_q.pop_front();
                    check_output("rsp_rdata", rsp_rdata, cur.rdata);
                    check_output("rsp_err", 64'(rsp_err), 64'(cur.err));
                    check_output("rsp_latency", 64'(lat), 64'(cur.lat));
                    check_output("sel_cycles", 64'(seen_sel), 64'(cur.n_sel));
                    check_output("write_cycles", 64'(seen_wr), 64'(cur.n_wr));
                    if (cur.n_wr > 0) check_output("clint_wdata", seen_wdata, cur.wdata);
                    if (cur.n_sel > 0) check_output("clint_addr", seen_addr, cur.caddr);
                end
                rsp_seen = 1'b0;
                idle_chk = 1'b1;
            end
        end
        if (req_valid && req_ready) begin
            acc_cycle = cycle;
            seen_sel  = 0;
            seen_wr   = 0;
        end
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 64'h0;
        req_wen      = 1'b0;
        req_wdata    = 64'h0;
        req_size     = SZ_B;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b1;
        fork
            begin
                while (!done) begin
                    @(negedge clock);
                    monitor_step();
                end
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                check_output("reset_req_ready", 64'(req_ready), 64'h1);
                check_output("reset_rsp_valid", 64'(rsp_valid), 64'h0);
                check_output("reset_rsp_rdata", rsp_rdata, 64'h0);
                check_output("reset_rsp_err", 64'(rsp_err), 64'h0);
                check_output("reset_clint_sel", 64'(clint_sel), 64'h0);
                check_output("reset_clint_wen", 64'(clint_wen), 64'h0);
                check_output("reset_clint_addr", clint_addr, 64'h0);
                check_output("reset_clint_wdata", clint_wdata, 64'h0);
                reset = 1'b0;

                // Dword store/load round trip on mtimecmp.
                apply_stimulus(64'h0200_4000, 1'b1, 64'h1122_3344_5566_7788, SZ_D, 1'b0,
                               64'h0, 1'b0, 2, 1, 1, 64'h1122_3344_5566_7788);
                drain();
                apply_stimulus(64'h0200_4000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h1122_3344_5566_7788, 1'b0, 3, 1, 0, 64'h0);
                drain();

                // Partial stores via read-modify-write; upper store-data bits must be ignored.
                apply_stimulus(64'h0200_4004, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF, SZ_W, 1'b0,
                               64'h0, 1'b0, 4, 2, 1, 64'hDEAD_BEEF_5566_7788);
                drain();
                apply_stimulus(64'h0200_4001, 1'b1, 64'h1234_5678_9ABC_DEAB, SZ_B, 1'b1,
                               64'h0, 1'b0, 4, 2, 1, 64'hDEAD_BEEF_5566_AB88);
                drain();
                apply_stimulus(64'h0200_4002, 1'b1, 64'h0000_0000_0000_1234, SZ_H, 1'b0,
                               64'h0, 1'b0, 4, 2, 1, 64'hDEAD_BEEF_1234_AB88);
                drain();
                apply_stimulus(64'h0200_4000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'hDEAD_BEEF_1234_AB88, 1'b0, 3, 1, 0, 64'h0);
                drain();

                // Sub-word loads with and without sign extension.
                apply_stimulus(64'h0200_4000, 1'b1, 64'h80FF_0000_0000_0011, SZ_D, 1'b0,
                               64'h0, 1'b0, 2, 1, 1, 64'h80FF_0000_0000_0011);
                drain();
                apply_stimulus(64'h0200_4000, 1'b0, 64'h0, SZ_B, 1'b0,
                               64'h0000_0000_0000_0011, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_4006, 1'b0, 64'h0, SZ_H, 1'b0,
                               64'hFFFF_FFFF_FFFF_80FF, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_4006, 1'b0, 64'h0, SZ_H, 1'b1,
                               64'h0000_0000_0000_80FF, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_4004, 1'b0, 64'h0, SZ_W, 1'b0,
                               64'hFFFF_FFFF_80FF_0000, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_4007, 1'b0, 64'h0, SZ_B, 1'b0,
                               64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1, 0, 64'h0);
                drain();

                // mtime, undecoded offsets and the last dword of the window.
                apply_stimulus(64'h0200_BFF8, 1'b1, 64'h0000_0000_0000_1234, SZ_D, 1'b0,
                               64'h0, 1'b0, 2, 1, 1, 64'h0000_0000_0000_1234);
                drain();
                apply_stimulus(64'h0200_BFF8, 1'b0, 64'h0, SZ_D, 1'b1,
                               64'h0000_0000_0000_1234, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_0008, 1'b1, 64'h0000_0000_0000_5555, SZ_D, 1'b0,
                               64'h0, 1'b0, 2, 1, 1, 64'h0000_0000_0000_5555);
                drain();
                apply_stimulus(64'h0200_0008, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h0, 1'b0, 3, 1, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_FFF8, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h0, 1'b0, 3, 1, 0, 64'h0);
                drain();

                // Error responses: no CLINT cycle, one-cycle turnaround.
                apply_stimulus(64'h0200_4001, 1'b0, 64'h0, SZ_H, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();
                apply_stimulus(64'h0300_0000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();
                apply_stimulus(64'h0201_0000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();
                apply_stimulus(64'h01FF_FFF8, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();
                apply_stimulus(64'h0200_4002, 1'b1, 64'h0000_0000_AAAA_AAAA, SZ_W, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();
                apply_stimulus(64'h0300_0000, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, SZ_D, 1'b0,
                               64'h0, 1'b1, 1, 0, 0, 64'h0);
                drain();

                // Back-pressure: response held while rsp_ready is low.
                @(posedge clock);
                #1;
                rsp_ready = 1'b0;
                apply_stimulus(64'h0200_4000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h80FF_0000_0000_0011, 1'b0, 3, 1, 0, 64'h0);
                begin
                    int waited;
                    waited = 0;
                    while (!rsp_valid && waited < 20) begin
                        @(posedge clock);
                        #1;
                        waited++;
                    end
                end
                repeat (5) @(posedge clock);
                #1;
                rsp_ready = 1'b1;
                drain();

                // Reset while the dword store is on the bus abandons the write.
                @(posedge clock);
                #1;
                req_valid    = 1'b1;
                req_addr     = 64'h0200_4000;
                req_wen      = 1'b1;
                req_wdata    = 64'hCAFE_F00D_CAFE_F00D;
                req_size     = SZ_D;
                req_unsigned = 1'b0;
                @(posedge clock);
                #1;
                req_valid = 1'b0;
                check_output("wr_issue_sel", 64'(clint_sel), 64'h1);
                check_output("wr_issue_wen", 64'(clint_wen), 64'h1);
                #2;
                reset = 1'b1;
                #1;
                check_output("reset_drops_sel", 64'(clint_sel), 64'h0);
                check_output("reset_drops_wen", 64'(clint_wen), 64'h0);
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b0;
                check_output("post_reset_req_ready", 64'(req_ready), 64'h1);
                check_output("post_reset_rsp_valid", 64'(rsp_valid), 64'h0);
                apply_stimulus(64'h0200_4000, 1'b0, 64'h0, SZ_D, 1'b0,
                               64'h80FF_0000_0000_0011, 1'b0, 3, 1, 0, 64'h0);
                drain();

                repeat (2) @(posedge clock);
                done = 1'b1;
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
